cpu_instruction_dumper: RTL and testbench

//  Reads a range of 24-bit words from instruction RAM and streams them out as bytes

---
 rtl/cpu_instruction_dumper.sv | 166 ++++++++++++++++
 tb/tb_cpu_instruction_dumper.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instruction_dumper.sv
// Streams a range of 24-bit iRAM words out as bytes (LSB first) over a 4-phase uart_tx
// handshake, optionally followed by a terminator word, while holding the CPU paused.
module cpu_instruction_dumper #(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter bit          SEND_TERMINATOR = 1'b1,
  parameter logic [23:0] TERMINATOR      = 24'hFFFF00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  iRAM_read_enable,
  output logic [ADDR_WIDTH-1:0] extern_iRAM_addr,
  input  logic [23:0]           iRAM_data_out,
  input  logic                  data_ack,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ack,
  output logic                  cpu_paused,
  output logic                  busy,
  output logic                  dump_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_TX_SEND = 3'd2;
  localparam logic [2:0] S_TX_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state, state_d;
  logic [23:0]           word_buf, word_buf_d;
  logic [1:0]            idx, idx_d;
  logic [ADDR_WIDTH-1:0] remaining, remaining_d;
  logic                  trailer_sent, trailer_sent_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  rd_en_d, tx_valid_d, cpu_paused_d, busy_d, dump_done_d;
  logic [7:0]            tx_data_d;
  logic                  load_byte;

  // Next-state and next-output logic; every register has a hold default
  always_comb begin
    state_d        = state;
    word_buf_d     = word_buf;
    idx_d          = idx;
    remaining_d    = remaining;
    trailer_sent_d = trailer_sent;
    addr_d         = extern_iRAM_addr;
    rd_en_d        = iRAM_read_enable;
    tx_valid_d     = tx_valid;
    tx_data_d      = tx_data;
    cpu_paused_d   = cpu_paused;
    busy_d         = busy;
    load_byte      = 1'b0;

    case (state)
      S_IDLE: begin
        if (dump_start) begin
          busy_d         = 1'b1;
          cpu_paused_d   = 1'b1;
          addr_d         = start_addr;
          remaining_d    = word_count;
          trailer_sent_d = 1'b0;
          idx_d          = 2'd0;
          if (word_count != '0) begin
            state_d = S_RD_REQ;
            rd_en_d = 1'b1;
          end else if (SEND_TERMINATOR) begin
            state_d        = S_TX_SEND;
            word_buf_d     = TERMINATOR;
            trailer_sent_d = 1'b1;
            load_byte      = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_REQ: begin
        if (data_ack) begin
          word_buf_d  = iRAM_data_out;
          rd_en_d     = 1'b0;
          idx_d       = 2'd0;
          remaining_d = remaining - ADDR_WIDTH'(1);
          state_d     = S_TX_SEND;
          load_byte   = 1'b1;
        end
      end
      S_TX_SEND: begin
        if (tx_ack) begin
          tx_valid_d = 1'b0;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // Next byte is only offered once the receiver has dropped its ack
        if (!tx_ack) begin
          if (idx != 2'd2) begin
            idx_d     = idx + 2'd1;
            state_d   = S_TX_SEND;
            load_byte = 1'b1;
          end else if (remaining != '0) begin
            addr_d  = extern_iRAM_addr + ADDR_WIDTH'(1);
            rd_en_d = 1'b1;
            state_d = S_RD_REQ;
          end else if (SEND_TERMINATOR && !trailer_sent) begin
            word_buf_d     = TERMINATOR;
            idx_d          = 2'd0;
            trailer_sent_d = 1'b1;
            state_d        = S_TX_SEND;
            load_byte      = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        cpu_paused_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    dump_done_d = (state_d == S_DONE);

    if (load_byte) begin
      tx_valid_d = 1'b1;
      case (idx_d)
        2'd0:    tx_data_d = word_buf_d[7:0];
        2'd1:    tx_data_d = word_buf_d[15:8];
        default: tx_data_d = word_buf_d[23:16];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      word_buf         <= '0;
      idx              <= '0;
      remaining        <= '0;
      trailer_sent     <= 1'b0;
      extern_iRAM_addr <= '0;
      iRAM_read_enable <= 1'b0;
      tx_valid         <= 1'b0;
      tx_data          <= '0;
      cpu_paused       <= 1'b0;
      busy             <= 1'b0;
      dump_done        <= 1'b0;
    end else begin
      state            <= state_d;
      word_buf         <= word_buf_d;
      idx              <= idx_d;
      remaining        <= remaining_d;
      trailer_sent     <= trailer_sent_d;
      extern_iRAM_addr <= addr_d;
      iRAM_read_enable <= rd_en_d;
      tx_valid         <= tx_valid_d;
      tx_data          <= tx_data_d;
      cpu_paused       <= cpu_paused_d;
      busy             <= busy_d;
      dump_done        <= dump_done_d;
    end
  end

endmodule

// File: tb/tb_cpu_instruction_dumper.sv
// Randomised bench for cpu_instruction_dumper: iRAM and uart_tx responders plus a
// queue-based reference of the expected byte stream and address sequence.
module tb_cpu_instruction_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_start, dump_start2;
  logic [7:0]  start_addr, word_count;
  logic        rd_en, data_ack, tx_valid, tx_ack, cpu_paused, busy, dump_done;
  logic [7:0]  addr, tx_data;
  logic [23:0] rdata;
  logic        rd_en2, tx_valid2, cpu_paused2, busy2, dump_done2;
  logic [7:0]  addr2, tx_data2;
  logic        data_ack2 = 1'b0;
  logic        tx_ack2 = 1'b0;
  logic [23:0] rdata2 = 24'h0;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] mem [256];
  logic [7:0]  byte_q[$];
  logic [7:0]  addr_q[$];
  int ack_delay = 0;
  int tx_delay  = 0;
  int stab_err  = 0;
  int done_cnt  = 0;
  int v2_seen   = 0;
  int rd2_seen  = 0;

  always #5 clk = ~clk;

  cpu_instruction_dumper dut (
    .clk(clk), .rst(rst), .dump_start(dump_start), .start_addr(start_addr),
    .word_count(word_count), .iRAM_read_enable(rd_en), .extern_iRAM_addr(addr),
    .iRAM_data_out(rdata), .data_ack(data_ack), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ack(tx_ack), .cpu_paused(cpu_paused), .busy(busy), .dump_done(dump_done)
  );

  cpu_instruction_dumper #(.ADDR_WIDTH(8), .SEND_TERMINATOR(1'b0), .TERMINATOR(24'hFFFF00)) dut2 (
    .clk(clk), .rst(rst), .dump_start(dump_start2), .start_addr(start_addr),
    .word_count(word_count), .iRAM_read_enable(rd_en2), .extern_iRAM_addr(addr2),
    .iRAM_data_out(rdata2), .data_ack(data_ack2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ack(tx_ack2), .cpu_paused(cpu_paused2), .busy(busy2), .dump_done(dump_done2)
  );

  // iRAM responder: one-cycle data_ack after ack_delay cycles of read_enable
  initial begin
    int rcnt;
    rcnt = 0;
    data_ack = 1'b0;
    rdata = 24'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        data_ack = 1'b0;
        rcnt = 0;
      end else if (data_ack) begin
        data_ack = 1'b0;
      end else if (rd_en) begin
        if (rcnt >= ack_delay) begin
          data_ack = 1'b1;
          rdata = mem[addr];
          addr_q.push_back(addr);
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  // uart_tx responder: accepts after tx_delay cycles, tracks data stability while pending
  initial begin
    int tcnt;
    logic pending;
    logic [7:0] held;
    tcnt = 0;
    pending = 1'b0;
    held = 8'h0;
    tx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_ack = 1'b0;
        tcnt = 0;
        pending = 1'b0;
      end else if (tx_ack) begin
        if (!tx_valid) tx_ack = 1'b0;
      end else if (tx_valid) begin
        if (!pending) begin
          pending = 1'b1;
          held = tx_data;
          tcnt = 0;
        end else if (tx_data !== held) begin
          stab_err++;
        end
        if (tcnt >= tx_delay) begin
          tx_ack = 1'b1;
          byte_q.push_back(held);
          pending = 1'b0;
        end else begin
          tcnt++;
        end
      end else if (pending) begin
        stab_err++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dump_done === 1'b1) done_cnt++;
      if (tx_valid2 === 1'b1) v2_seen++;
      if (rd_en2 === 1'b1) rd2_seen++;
    end
  end

  // Runs one dump on dut and checks it against the reference; poke>0 injects a busy dump_start
  task automatic do_dump(input string name, input logic [7:0] s, input logic [7:0] cnt,
                         input int adly, input int tdly, input int poke);
    logic [7:0]  exp_b[$];
    logic [7:0]  exp_a[$];
    logic [23:0] w;
    logic [23:0] term;
    logic [7:0]  a;
    int c;
    term = 24'hFFFF00;
    for (int i = 0; i < int'(cnt); i++) begin
      a = 8'(int'(s) + i);
      exp_a.push_back(a);
      w = mem[a];
      exp_b.push_back(w[7:0]);
      exp_b.push_back(w[15:8]);
      exp_b.push_back(w[23:16]);
    end
    exp_b.push_back(term[7:0]);
    exp_b.push_back(term[15:8]);
    exp_b.push_back(term[23:16]);

    @(negedge clk);
    byte_q.delete();
    addr_q.delete();
    stab_err = 0;
    done_cnt = 0;
    ack_delay = adly;
    tx_delay = tdly;
    start_addr = s;
    word_count = cnt;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    n_cmp++;
    if ({busy, cpu_paused, rd_en} !== {2'b11, cnt != 8'd0}) begin
      n_err++;
      $display("FAIL %s start_latency: busy,paused,rd_en=%b expected %b", name,
               {busy, cpu_paused, rd_en}, {2'b11, cnt != 8'd0});
    end
    if (cnt != 8'd0) begin
      n_cmp++;
      if (addr !== s) begin
        n_err++;
        $display("FAIL %s first_addr: got %h expected %h", name, addr, s);
      end
    end

    c = 0;
    while (c < 5000 && dump_done !== 1'b1) begin
      c++;
      if (poke > 0 && c == poke) begin
        dump_start = 1'b1;
        start_addr = ~s;
        word_count = cnt + 8'd5;
      end else begin
        dump_start = 1'b0;
      end
      @(negedge clk);
    end
    dump_start = 1'b0;
    n_cmp++;
    if (dump_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: dump_done=%b after %0d cycles expected 1", name, dump_done, c);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, cpu_paused, dump_done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s after_done: busy,paused,done=%b expected 000", name, {busy, cpu_paused, dump_done});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_err++;
      $display("FAIL %s tx_stability: %0d violations expected 0", name, stab_err);
    end
    n_cmp++;
    if (byte_q.size() != exp_b.size()) begin
      n_err++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, byte_q.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        n_cmp++;
        if (byte_q[i] !== exp_b[i]) begin
          n_err++;
          $display("FAIL %s byte[%0d]: got %h expected %h", name, i, byte_q[i], exp_b[i]);
        end
      end
    end
    n_cmp++;
    if (addr_q.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL %s addr_count: got %0d expected %0d", name, addr_q.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        n_cmp++;
        if (addr_q[i] !== exp_a[i]) begin
          n_err++;
          $display("FAIL %s addr[%0d]: got %h expected %h", name, i, addr_q[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dump_start = 1'b0;
    dump_start2 = 1'b0;
    start_addr = 8'h0;
    word_count = 8'h0;
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    #1;
    n_cmp++;
    if ({rd_en, addr, tx_data, tx_valid, cpu_paused, busy, dump_done} !== 21'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rd_en, addr, tx_data, tx_valid, cpu_paused, busy, dump_done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    mem[8'h10] = 24'hABCDEF;
    do_dump("single_word", 8'h10, 8'd1, 1, 2, 0);
  endtask

  task automatic test_wrap();
    do_dump("wrap", 8'hFE, 8'd3, 0, 1, 0);
  endtask

  task automatic test_zero_count();
    do_dump("zero_count_term", 8'h33, 8'd0, 0, 0, 0);
  endtask

  task automatic test_no_terminator();
    v2_seen = 0;
    rd2_seen = 0;
    @(negedge clk);
    word_count = 8'd0;
    start_addr = 8'h44;
    dump_start2 = 1'b1;
    @(negedge clk);
    dump_start2 = 1'b0;
    n_cmp++;
    if ({busy2, cpu_paused2, dump_done2} !== 3'b111) begin
      n_err++;
      $display("FAIL no_term_first: busy,paused,done=%b expected 111", {busy2, cpu_paused2, dump_done2});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy2, cpu_paused2, dump_done2} !== 3'b000) begin
      n_err++;
      $display("FAIL no_term_second: busy,paused,done=%b expected 000", {busy2, cpu_paused2, dump_done2});
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (v2_seen != 0 || rd2_seen != 0) begin
      n_err++;
      $display("FAIL no_term_activity: tx_valid cycles %0d, read cycles %0d expected 0 and 0", v2_seen, rd2_seen);
    end
  endtask

  task automatic test_backpressure();
    do_dump("backpressure", 8'($urandom), 8'd2, 5, 50, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      do_dump("random", 8'($urandom), 8'($urandom_range(1, 6)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
  endtask

  task automatic test_busy_start();
    do_dump("busy_start", 8'($urandom), 8'd2, 1, 1, 4);
  endtask

  task automatic test_async_reset();
    int c;
    @(negedge clk);
    byte_q.delete();
    done_cnt = 0;
    ack_delay = 1;
    tx_delay = 10;
    start_addr = 8'h20;
    word_count = 8'd3;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    c = 0;
    while (c < 2000 && !(byte_q.size() == 1 && tx_valid === 1'b1)) begin
      c++;
      @(negedge clk);
    end
    n_cmp++;
    if (!(byte_q.size() == 1 && tx_valid === 1'b1)) begin
      n_err++;
      $display("FAIL async_rst_reach: bytes %0d tx_valid %b expected 1 and 1", byte_q.size(), tx_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_en, addr, tx_data, tx_valid, cpu_paused, busy, dump_done} !== 21'h0) begin
      n_err++;
      $display("FAIL async_rst_outputs: got %h expected 0",
               {rd_en, addr, tx_data, tx_valid, cpu_paused, busy, dump_done});
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_err++;
      $display("FAIL async_rst_done: got %0d pulses expected 0", done_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_dump("after_reset", 8'h20, 8'd2, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_count();
    test_no_terminator();
    test_backpressure();
    test_random();
    test_busy_start();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
